// File: rtl/debug_hub.sv
// Board debug front-end: debounced buttons, addressable switch-capture channels with pending
// flags, CPU read port, debug register stepping and an 8-digit multiplexed hex display.
module debug_hub #(
  parameter int unsigned InW        = 16,
  parameter int unsigned NumCh      = 4,
  parameter logic [15:0] BaseAddr   = 16'h0000,
  parameter int unsigned Debounce   = 4,
  parameter bit          Wrap       = 1'b1,
  parameter logic [4:0]  RstDbgAddr = 5'd1,
  parameter int unsigned ScanDiv    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [InW-1:0]   sw_data_i,
  input  logic             wr_btn_i,
  input  logic [3:0]       ch_sel_i,
  input  logic             up_btn_i,
  input  logic             down_btn_i,
  input  logic [15:0]      cpu_rd_addr_i,
  input  logic             cpu_rd_en_i,
  output logic [31:0]      cpu_rd_data_o,
  output logic [NumCh-1:0] pending_o,
  output logic [4:0]       dbg_addr_o,
  input  logic [31:0]      dbg_data_i,
  output logic [7:0]       an_o,
  output logic [3:0]       digit_hex_o
);

  localparam int unsigned CntW  = $clog2(Debounce + 1);
  localparam int unsigned IdxW  = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam int unsigned ScanW = $clog2(ScanDiv);

  // Button conditioners: bit 0 = write, bit 1 = up, bit 2 = down.
  logic [2:0]           btn_raw;
  logic [2:0]           sync1_q, sync2_q, level_q, level_d, prev_q, pulse_q;
  logic [2:0][CntW-1:0] cnt_q, cnt_d;

  assign btn_raw = {down_btn_i, up_btn_i, wr_btn_i};

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntW'(Debounce - 1)) begin
        cnt_d[i]   = '0;
        level_d[i] = ~level_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
      pulse_q <= level_q & ~prev_q;
    end
  end

  logic wr_pulse, up_pulse, down_pulse;
  assign wr_pulse   = pulse_q[0];
  assign up_pulse   = pulse_q[1];
  assign down_pulse = pulse_q[2];

  // Channels, pending flags and CPU read port.
  logic [NumCh-1:0][31:0] chan_q, chan_d;
  logic [NumCh-1:0]       pend_q, pend_d;
  logic [31:0]            rd_data_q, rd_data_d;
  logic [15:0]            rd_off;
  logic                   rd_hit;
  logic [IdxW-1:0]        rd_idx, wr_idx;

  assign rd_off = cpu_rd_addr_i - BaseAddr;
  assign rd_hit = (cpu_rd_addr_i >= BaseAddr) && (32'(rd_off) < NumCh);
  assign rd_idx = rd_off[IdxW-1:0];
  assign wr_idx = IdxW'(ch_sel_i);

  always_comb begin
    chan_d    = chan_q;
    pend_d    = pend_q;
    rd_data_d = rd_data_q;
    if (cpu_rd_en_i) begin
      if (rd_hit) begin
        rd_data_d      = chan_q[rd_idx];
        pend_d[rd_idx] = 1'b0;
      end else begin
        rd_data_d = '0;
      end
    end
    // Applied after the read so a same-cycle write leaves the flag set.
    if (wr_pulse && (32'(ch_sel_i) < NumCh)) begin
      chan_d[wr_idx] = 32'(sw_data_i);
      pend_d[wr_idx] = 1'b1;
    end
  end

  // Debug address stepping.
  logic [4:0] dbg_q, dbg_d;

  always_comb begin
    dbg_d = dbg_q;
    if (up_pulse && !down_pulse) begin
      dbg_d = (dbg_q == 5'd31) ? (Wrap ? 5'd0 : 5'd31) : dbg_q + 5'd1;
    end else if (down_pulse && !up_pulse) begin
      dbg_d = (dbg_q == 5'd0) ? (Wrap ? 5'd31 : 5'd0) : dbg_q - 5'd1;
    end
  end

  // Display scan; snapshot reloads only when entering digit 0 so a frame never tears.
  logic [ScanW-1:0] scan_q, scan_d;
  logic [2:0]       digit_q, digit_d;
  logic [31:0]      snap_q, snap_d;
  logic [7:0]       an_q, an_d;
  logic [3:0]       hex_q, hex_d;

  always_comb begin
    scan_d  = scan_q + 1'b1;
    digit_d = digit_q;
    snap_d  = snap_q;
    an_d    = an_q;
    hex_d   = hex_q;
    if (scan_q == ScanW'(ScanDiv - 1)) begin
      scan_d  = '0;
      digit_d = digit_q + 3'd1;
      if (digit_d == 3'd0) begin
        snap_d = dbg_data_i;
      end
      an_d  = ~(8'd1 << digit_d);
      hex_d = snap_d[{digit_d, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chan_q    <= '0;
      pend_q    <= '0;
      rd_data_q <= '0;
      dbg_q     <= RstDbgAddr;
      scan_q    <= '0;
      digit_q   <= '0;
      snap_q    <= '0;
      an_q      <= 8'hFE;
      hex_q     <= '0;
    end else begin
      chan_q    <= chan_d;
      pend_q    <= pend_d;
      rd_data_q <= rd_data_d;
      dbg_q     <= dbg_d;
      scan_q    <= scan_d;
      digit_q   <= digit_d;
      snap_q    <= snap_d;
      an_q      <= an_d;
      hex_q     <= hex_d;
    end
  end

  assign cpu_rd_data_o = rd_data_q;
  assign pending_o     = pend_q;
  assign dbg_addr_o    = dbg_q;
  assign an_o          = an_q;
  assign digit_hex_o   = hex_q;

endmodule
